// File: rtl/ps2_key_event.sv
// PS/2 keyboard front end: pin conditioning, 11-bit frame deframing and
// reduction of the make/break/extended byte stream to single-cycle key events.
module ps2_key_event #(
    parameter int FILTER_LEN      = 8,
    parameter int TIMEOUT_CYCLES  = 200000,
    parameter bit SUPPRESS_REPEAT = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scancode,
    output logic       extended,
    output logic       push_down,
    output logic       push_up,
    output logic       frame_err
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_EXT, ST_BRK, ST_SKIP} state_t;

    logic [1:0]    r_clk_sync, r_dat_sync;
    logic          r_clk_flt, r_clk_flt_d;
    logic [FW-1:0] r_flt_cnt;
    logic          w_fall, w_dat;

    // Conditioning: synchronizers, then the clock only moves after FILTER_LEN agreeing samples
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_clk_sync  <= 2'b11;
            r_dat_sync  <= 2'b11;
            r_clk_flt   <= 1'b1;
            r_clk_flt_d <= 1'b1;
            r_flt_cnt   <= '0;
        end else begin
            r_clk_sync  <= {r_clk_sync[0], ps2_clk};
            r_dat_sync  <= {r_dat_sync[0], ps2_data};
            r_clk_flt_d <= r_clk_flt;
            if (r_clk_sync[1] == r_clk_flt) begin
                r_flt_cnt <= '0;
            end else if (r_flt_cnt == FW'(FILTER_LEN - 1)) begin
                r_clk_flt <= r_clk_sync[1];
                r_flt_cnt <= '0;
            end else begin
                r_flt_cnt <= r_flt_cnt + 1'b1;
            end
        end
    end

    assign w_fall = r_clk_flt_d & ~r_clk_flt;
    assign w_dat  = r_dat_sync[1];

    logic [3:0]    r_idx;
    logic [7:0]    r_shift, r_byte;
    logic          r_byte_vld, r_frame_err;
    logic [TW-1:0] r_tmo;

    // Deframer: one bit per filtered falling edge, aborted on bad framing or timeout
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx       <= '0;
            r_shift     <= '0;
            r_byte      <= '0;
            r_byte_vld  <= 1'b0;
            r_frame_err <= 1'b0;
            r_tmo       <= '0;
        end else begin
            r_byte_vld  <= 1'b0;
            r_frame_err <= 1'b0;
            if (r_idx == 4'd0 || w_fall) begin
                r_tmo <= '0;
            end else if (r_tmo != TW'(TIMEOUT_CYCLES)) begin
                r_tmo <= r_tmo + 1'b1;
            end
            if (w_fall) begin
                case (r_idx)
                    4'd0: begin
                        if (!w_dat) r_idx       <= 4'd1;
                        else        r_frame_err <= 1'b1;
                    end
                    4'd9: begin
                        if (^{r_shift, w_dat}) begin
                            r_idx <= 4'd10;
                        end else begin
                            r_idx       <= 4'd0;
                            r_frame_err <= 1'b1;
                        end
                    end
                    4'd10: begin
                        r_idx <= 4'd0;
                        if (w_dat) begin
                            r_byte     <= r_shift;
                            r_byte_vld <= 1'b1;
                        end else begin
                            r_frame_err <= 1'b1;
                        end
                    end
                    default: begin
                        r_shift <= {w_dat, r_shift[7:1]};
                        r_idx   <= r_idx + 4'd1;
                    end
                endcase
            end else if (r_idx != 4'd0 && r_tmo == TW'(TIMEOUT_CYCLES)) begin
                r_idx       <= 4'd0;
                r_frame_err <= 1'b1;
            end
        end
    end

    state_t     r_state, w_state_nx;
    logic       r_ext_f, r_brk_f, w_ext_nx, w_brk_nx;
    logic [2:0] r_skip, w_skip_nx;
    logic       r_held_v, w_held_v_nx;
    logic [8:0] r_held, w_held_nx;
    logic [7:0] r_scancode, w_scancode_nx;
    logic       r_extended, w_extended_nx;
    logic       r_push_down, w_push_down_nx, r_push_up, w_push_up_nx;
    logic       w_drop, w_match;

    // Decoder: prefix tracking, Pause skipping and repeat suppression
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_ext_f     <= 1'b0;
            r_brk_f     <= 1'b0;
            r_skip      <= '0;
            r_held_v    <= 1'b0;
            r_held      <= '0;
            r_scancode  <= '0;
            r_extended  <= 1'b0;
            r_push_down <= 1'b0;
            r_push_up   <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_ext_f     <= w_ext_nx;
            r_brk_f     <= w_brk_nx;
            r_skip      <= w_skip_nx;
            r_held_v    <= w_held_v_nx;
            r_held      <= w_held_nx;
            r_scancode  <= w_scancode_nx;
            r_extended  <= w_extended_nx;
            r_push_down <= w_push_down_nx;
            r_push_up   <= w_push_up_nx;
        end
    end

    // Acknowledge, self-test and error responses carry no key information
    assign w_drop  = r_byte inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF};
    assign w_match = r_held_v && (r_held == {r_ext_f, r_byte});

    always_comb begin
        w_state_nx     = r_state;
        w_ext_nx       = r_ext_f;
        w_brk_nx       = r_brk_f;
        w_skip_nx      = r_skip;
        w_held_v_nx    = r_held_v;
        w_held_nx      = r_held;
        w_scancode_nx  = r_scancode;
        w_extended_nx  = r_extended;
        w_push_down_nx = 1'b0;
        w_push_up_nx   = 1'b0;
        if (r_frame_err) begin
            w_state_nx = ST_IDLE;
            w_ext_nx   = 1'b0;
            w_brk_nx   = 1'b0;
            w_skip_nx  = '0;
        end else if (r_byte_vld) begin
            if (w_drop) begin
                w_state_nx = ST_IDLE;
                w_ext_nx   = 1'b0;
                w_brk_nx   = 1'b0;
                w_skip_nx  = '0;
            end else if (r_state == ST_SKIP) begin
                w_skip_nx = r_skip - 3'd1;
                if (r_skip == 3'd1) w_state_nx = ST_IDLE;
            end else if (r_byte == 8'hE0) begin
                w_ext_nx   = 1'b1;
                w_state_nx = ST_EXT;
            end else if (r_byte == 8'hF0) begin
                w_brk_nx   = 1'b1;
                w_state_nx = ST_BRK;
            end else if (r_byte == 8'hE1 && r_state == ST_IDLE) begin
                w_skip_nx  = 3'd7;
                w_state_nx = ST_SKIP;
            end else begin
                w_state_nx = ST_IDLE;
                w_ext_nx   = 1'b0;
                w_brk_nx   = 1'b0;
                if (r_brk_f) begin
                    w_push_up_nx  = 1'b1;
                    w_scancode_nx = r_byte;
                    w_extended_nx = r_ext_f;
                    if (w_match) w_held_v_nx = 1'b0;
                end else if (!(w_match && SUPPRESS_REPEAT)) begin
                    w_push_down_nx = 1'b1;
                    w_scancode_nx  = r_byte;
                    w_extended_nx  = r_ext_f;
                    w_held_nx      = {r_ext_f, r_byte};
                    w_held_v_nx    = 1'b1;
                end
            end
        end
    end

    assign scancode  = r_scancode;
    assign extended  = r_extended;
    assign push_down = r_push_down;
    assign push_up   = r_push_up;
    assign frame_err = r_frame_err;
endmodule

// File: tb/tb_ps2_key_event.sv
// Bench for ps2_key_event: table of byte sequences, hand-built error/glitch/reset
// cases and random byte streams against a byte-level reference model.
module tb_ps2_key_event;
    localparam int FL  = 8;
    localparam int TMO = 300;
    localparam int H   = 16;
    localparam int LAT = FL + 4;

    logic       clk = 1'b0;
    logic       rst_n, ps2_clk, ps2_data;
    logic [7:0] scancode;
    logic       extended, push_down, push_up, frame_err;

    ps2_key_event #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TMO), .SUPPRESS_REPEAT(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .scancode(scancode), .extended(extended), .push_down(push_down),
        .push_up(push_up), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       down;
        logic [7:0] code;
        logic       ext;
        int         cyc;
    } ev_t;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   mon_viol = 0;
    logic prev_push = 1'b0;
    ev_t  q_ev[$];
    int   q_err[$];
    int   fall_cyc[11];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (push_down && push_up) mon_viol <= mon_viol + 1;
            if ((push_down || push_up) && prev_push) mon_viol <= mon_viol + 1;
            if (push_down || push_up) q_ev.push_back('{push_down, scancode, extended, cyc});
            if (frame_err) q_err.push_back(cyc);
        end
        prev_push <= push_down | push_up;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: byte-level key rules
    logic       m_ext, m_brk, m_held_v, m_extd;
    int         m_skip;
    logic [8:0] m_held;
    logic [7:0] m_code;

    task automatic model_reset();
        m_ext = 0; m_brk = 0; m_skip = 0; m_held_v = 0; m_held = '0; m_code = '0; m_extd = 0;
    endtask

    task automatic model_abort();
        m_ext = 0; m_brk = 0; m_skip = 0;
    endtask

    task automatic model_byte(input logic [7:0] b, output bit ev, output bit up,
                              output logic [7:0] code, output logic ext);
        ev = 0; up = 0; code = m_code; ext = m_extd;
        if (b == 8'hAA || b == 8'hFA || b == 8'hFE || b == 8'hEE || b == 8'h00 || b == 8'hFF) begin
            model_abort();
        end else if (m_skip > 0) begin
            m_skip--;
        end else if (b == 8'hE0) begin
            m_ext = 1;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else if (b == 8'hE1 && !m_ext && !m_brk) begin
            m_skip = 7;
        end else begin
            if (m_brk) begin
                ev = 1; up = 1; code = b; ext = m_ext;
                if (m_held_v && m_held == {m_ext, b}) m_held_v = 0;
            end else if (!(m_held_v && m_held == {m_ext, b})) begin
                ev = 1; code = b; ext = m_ext;
                m_held = {m_ext, b}; m_held_v = 1;
            end
            if (ev) begin m_code = code; m_extd = ext; end
            m_ext = 0; m_brk = 0;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [10:0] frame(input logic [7:0] b, input logic badpar);
        return {1'b1, (~^b) ^ badpar, b, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] bits, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            tick(H / 2);
            ps2_clk = 1'b0;
            fall_cyc[i] = cyc;
            tick(H);
            ps2_clk = 1'b1;
            tick(H / 2);
        end
        ps2_data = 1'b1;
    endtask

    task automatic send_and_check(input logic [7:0] b, output int obs_n, output logic obs_up,
                                  output logic [7:0] obs_code, output logic obs_ext);
        bit         ev, up;
        logic [7:0] code;
        logic       ext;
        ev_t        e;
        model_byte(b, ev, up, code, ext);
        send_bits(frame(b, 1'b0), 11);
        obs_n = q_ev.size(); obs_up = 0; obs_code = '0; obs_ext = 0;
        check("no_frame_err", q_err.size(), 0);
        check("event_count", obs_n, {31'd0, ev});
        if (obs_n > 0) begin
            e = q_ev[0];
            obs_up = !e.down; obs_code = e.code; obs_ext = e.ext;
            if (ev) begin
                check("event_dir_up", {31'd0, !e.down}, {31'd0, up});
                check("event_code", e.code, code);
                check("event_ext", e.ext, ext);
                check("event_latency", e.cyc - fall_cyc[10], LAT);
            end
        end
        q_ev.delete();
        q_err.delete();
        check("scancode_hold", scancode, m_code);
        check("extended_hold", extended, m_extd);
    endtask

    typedef struct {
        logic [7:0] b[8];
        int         n;
        bit         ev;
        bit         up;
        logic [7:0] code;
        bit         ext;
    } vec_t;

    vec_t vecs[15];

    initial begin
        int         on;
        logic       oup, oext;
        logic [7:0] ocode;
        logic [7:0] pool[16];

        vecs[0]  = '{'{8'h1C, 0, 0, 0, 0, 0, 0, 0}, 1, 1, 0, 8'h1C, 0};
        vecs[1]  = '{'{8'hF0, 8'h1C, 0, 0, 0, 0, 0, 0}, 2, 1, 1, 8'h1C, 0};
        vecs[2]  = '{'{8'hE0, 8'hF0, 8'h75, 0, 0, 0, 0, 0}, 3, 1, 1, 8'h75, 1};
        vecs[3]  = '{'{8'hE0, 8'h75, 0, 0, 0, 0, 0, 0}, 2, 1, 0, 8'h75, 1};
        vecs[4]  = '{'{8'hE0, 8'h75, 0, 0, 0, 0, 0, 0}, 2, 0, 0, 8'h00, 0};
        vecs[5]  = '{'{8'hE0, 8'hF0, 8'h75, 0, 0, 0, 0, 0}, 3, 1, 1, 8'h75, 1};
        vecs[6]  = '{'{8'hAA, 8'h12, 0, 0, 0, 0, 0, 0}, 2, 1, 0, 8'h12, 0};
        vecs[7]  = '{'{8'h12, 0, 0, 0, 0, 0, 0, 0}, 1, 0, 0, 8'h00, 0};
        vecs[8]  = '{'{8'h12, 0, 0, 0, 0, 0, 0, 0}, 1, 0, 0, 8'h00, 0};
        vecs[9]  = '{'{8'hF0, 8'h12, 0, 0, 0, 0, 0, 0}, 2, 1, 1, 8'h12, 0};
        vecs[10] = '{'{8'hE0, 8'hFA, 8'h1C, 0, 0, 0, 0, 0}, 3, 1, 0, 8'h1C, 0};
        vecs[11] = '{'{8'hF0, 8'hE0, 8'h1C, 0, 0, 0, 0, 0}, 3, 1, 1, 8'h1C, 1};
        vecs[12] = '{'{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77}, 8, 0, 0, 8'h00, 0};
        vecs[13] = '{'{8'h1C, 0, 0, 0, 0, 0, 0, 0}, 1, 0, 0, 8'h00, 0};
        vecs[14] = '{'{8'hF0, 8'h1C, 0, 0, 0, 0, 0, 0}, 2, 1, 1, 8'h1C, 0};
        pool = '{8'h1C, 8'h12, 8'h58, 8'h75, 8'h14, 8'h1C, 8'h12, 8'hE0,
                 8'hE0, 8'hF0, 8'hF0, 8'hF0, 8'hE1, 8'hAA, 8'hFA, 8'h29};

        rst_n = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1;
        model_reset();
        tick(5);
        check("reset_scancode", scancode, 8'h00);
        check("reset_extended", extended, 1'b0);
        check("reset_push_down", push_down, 1'b0);
        check("reset_push_up", push_up, 1'b0);
        check("reset_frame_err", frame_err, 1'b0);
        rst_n = 1'b1;
        tick(5);

        for (int v = 0; v < 15; v++) begin
            for (int k = 0; k < vecs[v].n; k++) begin
                send_and_check(vecs[v].b[k], on, oup, ocode, oext);
                tick(3);
            end
            check("tbl_event_count", on, {31'd0, vecs[v].ev});
            if (vecs[v].ev) begin
                check("tbl_up", oup, vecs[v].up);
                check("tbl_code", ocode, vecs[v].code);
                check("tbl_ext", oext, vecs[v].ext);
            end
        end

        // Parity error: 0x58 with even parity, device gives up before stop
        send_bits(frame(8'h58, 1'b1), 10);
        tick(20);
        check("parity_err_count", q_err.size(), 1);
        if (q_err.size() > 0) check("parity_err_latency", q_err[0] - fall_cyc[9], FL + 3);
        check("parity_no_event", q_ev.size(), 0);
        q_err.delete(); q_ev.delete();
        model_abort();
        send_and_check(8'h58, on, oup, ocode, oext);
        check("parity_recover_code", ocode, 8'h58);

        // Timeout after 5 bits
        send_bits(frame(8'h12, 1'b0), 5);
        tick(TMO + 60);
        check("timeout_err_count", q_err.size(), 1);
        if (q_err.size() > 0) check("timeout_err_latency", q_err[0] - fall_cyc[4], FL + 4 + TMO);
        check("timeout_no_event", q_ev.size(), 0);
        q_err.delete(); q_ev.delete();
        model_abort();
        send_and_check(8'h12, on, oup, ocode, oext);
        check("timeout_recover_code", ocode, 8'h12);

        // Short glitch on the clock pin must not start a frame
        tick(5);
        ps2_clk = 1'b0; tick(3); ps2_clk = 1'b1;
        tick(TMO + 50);
        check("glitch_no_err", q_err.size(), 0);
        check("glitch_no_event", q_ev.size(), 0);
        send_and_check(8'h1C, on, oup, ocode, oext);

        // Reset in the middle of a frame
        send_bits(frame(8'h33, 1'b0), 7);
        rst_n = 1'b0;
        tick(4);
        check("midrst_scancode", scancode, 8'h00);
        check("midrst_extended", extended, 1'b0);
        check("midrst_push_down", push_down, 1'b0);
        check("midrst_push_up", push_up, 1'b0);
        check("midrst_frame_err", frame_err, 1'b0);
        rst_n = 1'b1;
        model_reset();
        tick(TMO + 50);
        check("midrst_no_err", q_err.size(), 0);
        q_err.delete(); q_ev.delete();
        send_and_check(8'h1C, on, oup, ocode, oext);
        check("midrst_decode_down", {31'd0, on == 1 && !oup}, 1);

        // Random byte stream against the model
        for (int r = 0; r < 40; r++) begin
            tick($urandom_range(1, 20));
            send_and_check(pool[$urandom_range(0, 15)], on, oup, ocode, oext);
        end

        tick(5);
        check("pulse_rules", mon_viol, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/ps2_key_event.md
# ps2_key_event

Front end of the keyboard path: samples the raw PS/2 clock/data lines, deframes 11-bit device-to-host frames, and reduces the byte stream (make codes, 0xF0 break prefix, 0xE0 extended prefix) to single-cycle key events. Sits directly upstream of the scancode-to-ASCII stage. It supplies that stage's `scancode`, `push_down` and `push_up` inputs, which the stage uses for shift, caps-lock and language tracking and for ROM lookup.

## Interface
- `FILTER_LEN`, 8: consecutive identical synchronized samples required before the filtered PS/2 clock changes level.
- `TIMEOUT_CYCLES`, 200000: idle `clk` cycles allowed between PS/2 clock falling edges inside a frame before the frame is aborted (2 ms at 100 MHz).
- `SUPPRESS_REPEAT`, 1: when 1, typematic repeats of the currently held make code produce no `push_down`.
- `clk` input 1: system clock; all logic on rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `ps2_clk` input 1: raw PS/2 clock pin, asynchronous.
- `ps2_data` input 1: raw PS/2 data pin, asynchronous.
- `scancode` output 8: code of the most recent emitted event, held until the next event.
- `extended` output 1: 1 if the most recent event carried a 0xE0 prefix; held with `scancode`.
- `push_down` output 1: one-cycle pulse for a key press (make).
- `push_up` output 1: one-cycle pulse for a key release (break).
- `frame_err` output 1: one-cycle pulse when a frame is discarded.

## Operation
- Input conditioning:
  - Both pins pass through 2-FF synchronizers.
  - The clock pin then passes a glitch filter. The filtered level takes the synchronized value only after `FILTER_LEN` equal consecutive samples. Filtered level resets to 1.
- Data is sampled on each filtered-clock falling edge, using the synchronized data value of that cycle.
- Deframer, bit index 0..10:
  - Bit 0 is start and must be 0. Bits 1-8 are data, LSB first. Bit 9 is parity; data plus parity must have an odd number of ones. Bit 10 is stop and must be 1.
  - A bad start, parity or stop bit pulses `frame_err`, discards the byte, resets the decoder to IDLE and returns the index to 0.
  - Timeout: if the index is nonzero and `TIMEOUT_CYCLES` cycles pass without a falling edge, the frame is aborted with the same error action.
- Byte decoder FSM, states IDLE, EXT, BRK, SKIP. Flags `ext_f` and `brk_f` are latched while in these states.
  - 0xE0 sets `ext_f` and enters EXT.
  - 0xF0 sets `brk_f` and enters BRK. Both flags can be set together (E0 F0 xx).
  - 0xE1 received in IDLE enters SKIP and drops the next 7 bytes, i.e. the Pause sequence. No event is emitted; the FSM then returns to IDLE.
  - 0xAA, 0xFA, 0xFE, 0xEE, 0x00 and 0xFF in any state are dropped. Flags clear and the FSM returns to IDLE.
  - Any other byte emits an event:
    - `scancode` takes the byte and `extended` takes `ext_f`.
    - If `brk_f` is set, `push_up` pulses; otherwise `push_down` pulses.
    - Flags then clear and the FSM returns to IDLE.
- Repeat suppression:
  - A register `held` (9 bits: ext + code, plus a valid bit) records the last make.
  - A make equal to `held` while `held` is valid is a repeat. When `SUPPRESS_REPEAT` = 1, a repeat emits nothing and leaves `scancode` unchanged.
  - A break equal to `held` invalidates it. A different make replaces it.
- `push_down` and `push_up` are never asserted together and never asserted for two consecutive cycles.

## Timing
- Reset values: `scancode` 0x00, `extended` 0, `push_down` 0, `push_up` 0, `frame_err` 0. Bit index 0, FSM IDLE, flags clear, `held` invalid, filtered clock 1, timeout counter 0.
- Reset wins over any simultaneous event. Reset mid-frame drops the partial byte with no `frame_err`.
- Event latency: `push_*`, `scancode` and `extended` update exactly 2 `clk` cycles after the cycle in which the stop-bit falling edge is detected on the filtered clock (1 cycle byte-valid, 1 cycle decode).
- Error latency: `frame_err` asserts 1 cycle after the bad bit's edge, or 1 cycle after the timeout counter reaches `TIMEOUT_CYCLES`.
- Pin-to-edge delay: a filtered edge lags the pin by 2 + `FILTER_LEN` cycles. A pulse of `FILTER_LEN`-1 cycles or fewer on the pin never produces an edge.
- Timeout counter:
  - Clears on every falling edge and whenever the index is 0.
  - Saturates; it never wraps.
- The next frame may start on the edge after the stop bit. There is no minimum inter-frame gap.

## Test plan
- Clean make, then break: frame 0x1C, then F0, 0x1C → `push_down` pulse with `scancode`=0x1C, `extended`=0; later `push_up` pulse with `scancode`=0x1C; each 2 cycles after the respective stop edge.
- Extended break: bytes E0 F0 75 → one `push_up`, `scancode`=0x75, `extended`=1; no event emitted for the prefixes.
- Parity error: 0x58 sent with even parity → `frame_err` pulse, no `push_*`; the following valid 0x58 gives `push_down` with `scancode`=0x58.
- Timeout: 5 bits of a frame, then idle for `TIMEOUT_CYCLES` → `frame_err` 1 cycle later; the next full frame 0x12 gives `push_down` with 0x12.
- Typematic and Pause: with `SUPPRESS_REPEAT`=1, 0x12, 0x12, 0x12, F0 12 → exactly one `push_down` and one `push_up`. Pause bytes E1 14 77 E1 F0 14 F0 77 → no events.
- Glitch and reset: a 3-cycle low glitch on `ps2_clk` (with `FILTER_LEN`=8) → no bit sampled. `rst_n` low after bit 6 of a frame → all outputs 0, and the next complete frame decodes normally.
